// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined MIPS core: word and 256-bit block
// accesses served from an internal array after a programmable latency.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [31:0]  data_address_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [255:0] block_write_2DM,
  output logic [31:0]  data_read_fDM,
  output logic [255:0] block_read_fDM,
  output logic         mem_ready,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BRD, OP_BWR} op_t;

  state_t         state;
  op_t            op;
  op_t            req_op;
  logic           any_req;
  logic [7:0]     wait_cnt;
  logic [2:0]     beat;
  logic [AW-1:0]  widx;
  logic [31:0]    wdata;
  logic [255:0]   blk;
  logic [AW-1:0]  beat_idx;
  logic           wait_end;
  logic           accept;

  logic [31:0]    mem [DEPTH];
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [31:0]    mem_wdata;

  // Byte offset and bits above the array size are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{data_address_2DM[31:AW+2], data_address_2DM[1:0]};

  assign any_req  = dBlkWrite | dBlkRead | MemWrite | MemRead;
  assign accept   = (state == IDLE) && any_req;
  assign wait_end = (state == WAIT) && (wait_cnt == 8'd1);
  assign beat_idx = {widx[AW-1:3], beat};

  always_comb begin
    req_op = OP_RD;
    if (dBlkWrite)     req_op = OP_BWR;
    else if (dBlkRead) req_op = OP_BRD;
    else if (MemWrite) req_op = OP_WR;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = widx;
    mem_wdata = wdata;
    if (wait_end && op == OP_WR) begin
      mem_we = 1'b1;
    end else if (state == XFER && op == OP_BWR) begin
      mem_we    = 1'b1;
      mem_waddr = beat_idx;
      mem_wdata = blk[{beat, 5'b0} +: 32];
    end
  end

  // Array contents are intentionally not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Request payload; blk doubles as the gather buffer for block reads.
  always_ff @(posedge CLK) begin
    if (accept) begin
      widx  <= data_address_2DM[AW+1:2];
      wdata <= data_write_2DM;
      blk   <= block_write_2DM;
    end else if (state == XFER && op == OP_BRD) begin
      blk[{beat, 5'b0} +: 32] <= mem[beat_idx];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      op             <= OP_RD;
      wait_cnt       <= 8'd0;
      beat           <= 3'd0;
      mem_ready      <= 1'b0;
      busy           <= 1'b0;
      data_read_fDM  <= 32'd0;
      block_read_fDM <= 256'd0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (any_req) begin
            state    <= WAIT;
            op       <= req_op;
            wait_cnt <= 8'(LATENCY);
            busy     <= 1'b1;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt == 8'd1) begin
            beat <= 3'd0;
            if (op == OP_BRD || op == OP_BWR) begin
              state <= XFER;
            end else begin
              state     <= DONE;
              mem_ready <= 1'b1;
              if (op == OP_RD) data_read_fDM <= mem[widx];
            end
          end
        end
        XFER: begin
          beat <= beat + 3'd1;
          if (beat == 3'd7) begin
            state     <= DONE;
            mem_ready <= 1'b1;
            // Last lane comes straight from the array; lanes 0..6 are already gathered.
            if (op == OP_BRD) block_read_fDM <= {mem[beat_idx], blk[223:0]};
          end
        end
        DONE: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, data, priority, aliasing,
// reset abort and held-request behaviour with LATENCY=4, DEPTH=1024.
module tb_dmem_responder;

  localparam int LAT = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         MemRead = 1'b0;
  logic         MemWrite = 1'b0;
  logic         dBlkRead = 1'b0;
  logic         dBlkWrite = 1'b0;
  logic [31:0]  data_address_2DM = '0;
  logic [31:0]  data_write_2DM = '0;
  logic [255:0] block_write_2DM = '0;
  logic [31:0]  data_read_fDM;
  logic [255:0] block_read_fDM;
  logic         mem_ready;
  logic         busy;

  int checks = 0;
  int failures = 0;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite),
    .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
    .block_write_2DM(block_write_2DM),
    .data_read_fDM(data_read_fDM), .block_read_fDM(block_read_fDM),
    .mem_ready(mem_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, drop it after acceptance, measure edges to mem_ready.
  task automatic do_op(input string tag, input logic rd, input logic wr,
                       input logic brd, input logic bwr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [255:0] bw, input int exp_lat);
    int lat;
    @(posedge CLK); #1;
    MemRead = rd; MemWrite = wr; dBlkRead = brd; dBlkWrite = bwr;
    data_address_2DM = addr; data_write_2DM = wd; block_write_2DM = bw;
    @(posedge CLK); #1;
    MemRead = 0; MemWrite = 0; dBlkRead = 0; dBlkWrite = 0;
    data_address_2DM = 32'hFFFF_FFFF; data_write_2DM = 32'h0BAD_0BAD; block_write_2DM = '1;
    chk({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    while (!mem_ready && lat < 400) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    @(posedge CLK); #1;
    chk({tag, "_pulse"}, mem_ready, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  logic [255:0] pat1, pat2, old3, new3;
  int n;

  initial begin
    for (int i = 0; i < 8; i++) begin
      pat1[32*i +: 32] = 32'h1111_1111 * (i + 1);
      pat2[32*i +: 32] = 32'hC000_0000 + i;
      old3[32*i +: 32] = 32'h0000_AAA0 + i;
      new3[32*i +: 32] = 32'h5EED_0000 + i;
    end

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dread", data_read_fDM, 32'd0);
    chk("rst_bread", block_read_fDM, 256'd0);
    RESET = 1'b1;

    // Word write then read
    do_op("ww40", 0, 1, 0, 0, 32'h40, 32'hDEAD_BEEF, '0, LAT);
    chk("ww40_noread", data_read_fDM, 32'd0);
    do_op("wr40", 1, 0, 0, 0, 32'h40, '0, '0, LAT);
    chk("wr40_data", data_read_fDM, 32'hDEAD_BEEF);
    do_op("wr43", 1, 0, 0, 0, 32'h43, '0, '0, LAT);
    chk("wr43_data", data_read_fDM, 32'hDEAD_BEEF);

    // Block write then word/block reads
    do_op("bw100", 0, 0, 0, 1, 32'h100, '0, pat1, LAT + 8);
    do_op("wr114", 1, 0, 0, 0, 32'h114, '0, '0, LAT);
    chk("wr114_data", data_read_fDM, 32'h6666_6666);
    do_op("br11c", 0, 0, 1, 0, 32'h11C, '0, '0, LAT + 8);
    chk("br11c_data", block_read_fDM, pat1);
    chk("br11c_keepword", data_read_fDM, 32'h6666_6666);

    // Priority: block write wins over word write and word read
    do_op("prio", 1, 1, 0, 1, 32'h300, 32'hBADB_AD00, pat2, LAT + 8);
    chk("prio_noread", data_read_fDM, 32'h6666_6666);
    chk("prio_keepblk", block_read_fDM, pat1);
    do_op("wr300", 1, 0, 0, 0, 32'h300, '0, '0, LAT);
    chk("wr300_data", data_read_fDM, 32'hC000_0000);
    do_op("wr304", 1, 0, 0, 0, 32'h304, '0, '0, LAT);
    chk("wr304_data", data_read_fDM, 32'hC000_0001);

    // Aliasing modulo DEPTH
    do_op("ww1000", 0, 1, 0, 0, 32'h1000, 32'hA5A5_A5A5, '0, LAT);
    do_op("wr0", 1, 0, 0, 0, 32'h0, '0, '0, LAT);
    chk("wr0_data", data_read_fDM, 32'hA5A5_A5A5);

    // Reset abort during block write after beat 2 commits
    do_op("bw200old", 0, 0, 0, 1, 32'h200, '0, old3, LAT + 8);
    @(posedge CLK); #1;
    dBlkWrite = 1; data_address_2DM = 32'h200; block_write_2DM = new3;
    @(posedge CLK); #1;
    dBlkWrite = 0;
    n = 0;
    repeat (LAT + 3) begin
      @(posedge CLK); #1;
      if (mem_ready) n++;
    end
    RESET = 1'b0;
    #1;
    chk("abort_noready", n, 0);
    chk("abort_ready", mem_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_dread", data_read_fDM, 32'd0);
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b1;
    do_op("ab200", 1, 0, 0, 0, 32'h200, '0, '0, LAT);
    chk("ab200_data", data_read_fDM, 32'h5EED_0000);
    do_op("ab204", 1, 0, 0, 0, 32'h204, '0, '0, LAT);
    chk("ab204_data", data_read_fDM, 32'h5EED_0001);
    do_op("ab208", 1, 0, 0, 0, 32'h208, '0, '0, LAT);
    chk("ab208_data", data_read_fDM, 32'h5EED_0002);
    do_op("ab20c", 1, 0, 0, 0, 32'h20C, '0, '0, LAT);
    chk("ab20c_data", data_read_fDM, 32'h0000_AAA3);

    // Held request: MemRead stays high one cycle past DONE
    @(posedge CLK); #1;
    MemRead = 1; data_address_2DM = 32'h40;
    @(posedge CLK); #1;
    n = 0;
    while (!mem_ready && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("held_lat1", n, LAT);
    chk("held_data", data_read_fDM, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    n++;
    chk("held_idle", busy, 1'b0);
    @(posedge CLK); #1;
    n++;
    MemRead = 0;
    chk("held_reaccept", busy, 1'b1);
    while (!mem_ready && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("held_lat2", n, 2 * LAT + 2);
    @(posedge CLK); #1;
    chk("held_end", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
